conv_tile_engine: RTL

Parametrised successor to the fixed 4-lane convolution datapath. It sequences a complete output tile: address generation for the input-feature-map and weight buffers, a LANES-wide signed dot product, multi-pass accumulation, saturation, packing of LANES output channels into one word, and output-buffer writes. A start/busy/done handshake and zero-config error detection are added. It sits between the on-chip block RAMs (1-cycle read latency) and the host/sequencer that loads them.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/dot_lanes.sv | 30 +++
 rtl/conv_tile_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution tile engine.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAST = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Working width for the shift/saturate helper; wide enough for any sane ACC_W.
  localparam int SAT_W = 64;

  // Accumulator width that cannot overflow for LANES products summed over up to 2^CW-1 passes.
  function automatic int acc_w(input int lanes, input int dw, input int cw);
    return 2 * dw + $clog2(lanes) + cw;
  endfunction

  // Arithmetic right shift, then clamp to the signed range of a dw-bit value.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] v,
                                                         input int dw, input int sh);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/dot_lanes.sv
// Combinational LANES-wide signed dot product; lane 0 sits in the MSBs of each word.
module dot_lanes #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int OW    = 2 * DW + $clog2(LANES)
) (
  input  logic [LANES*DW-1:0] a_i,
  input  logic [LANES*DW-1:0] b_i,
  output logic signed [OW-1:0] sum_o
);

  logic signed [DW-1:0]   a_l;
  logic signed [DW-1:0]   b_l;
  logic signed [2*DW-1:0] prod;

  // Multiply each lane pair at full 2*DW precision and sum into the widened result.
  always_comb begin
    sum_o = '0;
    a_l   = '0;
    b_l   = '0;
    prod  = '0;
    for (int l = 0; l < LANES; l++) begin
      a_l   = a_i[(LANES-1-l)*DW +: DW];
      b_l   = b_i[(LANES-1-l)*DW +: DW];
      prod  = (2*DW)'(a_l) * (2*DW)'(b_l);
      sum_o = sum_o + OW'(prod);
    end
  end

endmodule

// File: rtl/conv_tile_engine.sv
// Output-tile sequencer: address generation, multi-pass accumulation, saturation,
// channel packing and output writes, with start/busy/done and zero-config error.
//
// state | meaning
// IDLE  | waiting for start; config latched on acceptance
// RD    | one IFM/weight read per cycle for k = 0..n_acc-1
// LAST  | fold in final read data, saturate into pack slot oc
// WR    | write packed word for pixel p
// DONE  | one-cycle done pulse
module conv_tile_engine
  import conv_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int CW    = 8,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CW-1:0]       n_pix,
  input  logic [CW-1:0]       n_acc,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ifm_en,
  output logic [AW-1:0]       ifm_addr,
  input  logic [LANES*DW-1:0] ifm_rdata,
  output logic                w_en,
  output logic [AW-1:0]       w_addr,
  input  logic [LANES*DW-1:0] w_rdata,
  output logic                out_we,
  output logic [AW-1:0]       out_addr,
  output logic [LANES*DW-1:0] out_wdata
);

  localparam int ACC_W = acc_w(LANES, DW, CW);
  localparam int DOT_W = 2 * DW + $clog2(LANES);
  localparam int OCW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [OCW-1:0] OC_LAST = OCW'(LANES - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           n_pix_q, n_pix_d, n_acc_q, n_acc_d;
  logic [CW-1:0]           p_q, p_d, k_q, k_d;
  logic [OCW-1:0]          oc_q, oc_d;
  logic [AW-1:0]           ifm_base_q, ifm_base_d, ifm_addr_q, ifm_addr_d, w_addr_q, w_addr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [LANES*DW-1:0]     pack_q, pack_d;
  logic                    err_q, err_d, vld_q;
  logic signed [DOT_W-1:0] dot;
  logic signed [SAT_W-1:0] sat_v;
  logic                    start_ok, zero_cfg;

  dot_lanes #(.LANES(LANES), .DW(DW)) u_dot (
    .a_i   (ifm_rdata),
    .b_i   (w_rdata),
    .sum_o (dot)
  );

  // abort has priority over a coincident start in IDLE
  assign start_ok = start && !abort;
  assign zero_cfg = (n_pix == '0) || (n_acc == '0);
  assign acc_sum  = acc_q + ACC_W'(dot);
  assign sat_v    = sat_shift(SAT_W'(acc_sum), DW, SHIFT);

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ifm_en    = (state_q == RD);
  assign w_en      = (state_q == RD);
  assign out_we    = (state_q == WR);
  assign ifm_addr  = ifm_addr_q;
  assign w_addr    = w_addr_q;
  assign out_addr  = AW'(p_q);
  assign out_wdata = pack_q;
  assign err       = err_q;

  // Next-state decode; abort from any active state returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = zero_cfg ? DONE : RD;
      RD:      if (k_q == '0) state_d = LAST;
      LAST:    state_d = (oc_q == OC_LAST) ? WR : RD;
      WR:      state_d = (p_q == n_pix_q - CW'(1)) ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Counters, running-adder addresses, accumulator and pack register.
  always_comb begin
    n_pix_d    = n_pix_q;
    n_acc_d    = n_acc_q;
    p_d        = p_q;
    k_d        = k_q;
    oc_d       = oc_q;
    ifm_base_d = ifm_base_q;
    ifm_addr_d = ifm_addr_q;
    w_addr_d   = w_addr_q;
    acc_d      = acc_q;
    pack_d     = pack_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: if (start_ok) begin
        n_pix_d    = n_pix;
        n_acc_d    = n_acc;
        err_d      = zero_cfg;
        p_d        = '0;
        oc_d       = '0;
        k_d        = n_acc - CW'(1);
        ifm_base_d = '0;
        ifm_addr_d = '0;
        w_addr_d   = '0;
        acc_d      = '0;
      end
      RD: begin
        ifm_addr_d = ifm_addr_q + AW'(1);
        w_addr_d   = w_addr_q + AW'(1);
        k_d        = k_q - CW'(1);
        // the first RD of a pass has no read data in flight yet
        if (vld_q) acc_d = acc_sum;
      end
      LAST: begin
        pack_d[(LANES-1-int'(oc_q))*DW +: DW] = sat_v[DW-1:0];
        acc_d = '0;
        k_d   = n_acc_q - CW'(1);
        if (oc_q == OC_LAST) begin
          oc_d = '0;
        end else begin
          // same pixel again for the next output channel; weights keep running
          oc_d       = oc_q + OCW'(1);
          ifm_addr_d = ifm_base_q;
        end
      end
      WR: begin
        p_d        = p_q + CW'(1);
        ifm_base_d = ifm_base_q + AW'(n_acc_q);
        ifm_addr_d = ifm_base_q + AW'(n_acc_q);
        w_addr_d   = '0;
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_pix_q    <= '0;
      n_acc_q    <= '0;
      p_q        <= '0;
      k_q        <= '0;
      oc_q       <= '0;
      ifm_base_q <= '0;
      ifm_addr_q <= '0;
      w_addr_q   <= '0;
      acc_q      <= '0;
      pack_q     <= '0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_pix_q    <= n_pix_d;
      n_acc_q    <= n_acc_d;
      p_q        <= p_d;
      k_q        <= k_d;
      oc_q       <= oc_d;
      ifm_base_q <= ifm_base_d;
      ifm_addr_q <= ifm_addr_d;
      w_addr_q   <= w_addr_d;
      acc_q      <= acc_d;
      pack_q     <= pack_d;
      err_q      <= err_d;
      vld_q      <= (state_q == RD);
    end
  end

endmodule
